neuron_tm_scheduler: RTL and testbench
======================================

Name: neuron_tm_scheduler

Overview:
- Time-multiplexes one shared LIF/STP neuron datapath across N_NEURONS virtual neurons.
- On each timestep tick it walks neuron IDs 0..N_NEURONS-1 in order. For each ID it fetches the synaptic current from the synapse accumulator, issues one clock-enabled update to the core, waits the core latency, samples the spike, and emits spike events over a valid/ready stream.
- Sits between the synapse accumulator, the neuron core and the spike router.

Parameters:
- N_NEURONS, 16, number of virtual neurons per timestep (≥2).
- NID_W, $clog2(N_NEURONS), neuron ID width.
- WEIGHT_W, 16, synaptic current width (signed).
- CORE_LAT, 1, cycles from core_en_o to valid core_spike_i (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_i  in  1  timestep start pulse.
- syn_req_o  out  1  synaptic current request.
- syn_nid_o  out  NID_W  neuron ID for the request.
- syn_ack_i  in  1  current valid; handshake completes when syn_req_o & syn_ack_i.
- syn_cur_i  in  WEIGHT_W signed  synaptic current.
- core_en_o  out  1  one-cycle clock enable to the core.
- core_nid_o  out  NID_W  neuron ID selecting the core state bank.
- core_isyn_o  out  WEIGHT_W signed  current to the core.
- core_spike_i  in  1  core spike result.
- ev_valid_o  out  1  spike event valid.
- ev_nid_o  out  NID_W  spiking neuron ID.
- ev_ready_i  in  1  downstream ready.
- busy_o  out  1  timestep in progress.
- done_o  out  1  one-cycle pulse when the timestep completes.
- spike_cnt_o  out  NID_W+1  spikes in the current/last timestep.
- overrun_o  out  1  sticky; a tick arrived while not IDLE.
- ovr_clr_i  in  1  clears overrun_o.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, neuron ID counter 0, latched current 0.
- FSM states: IDLE, FETCH, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - On tick_i: clear spike_cnt_o and the ID counter, go to FETCH.
  - busy_o=1 in every state except IDLE.
- FETCH:
  - syn_req_o=1 and syn_nid_o=ID, held until syn_ack_i (no timeout).
  - On ack: latch syn_cur_i, go to ISSUE.
- ISSUE: core_en_o=1 for exactly one cycle; core_nid_o=ID and core_isyn_o=latched current (both held stable from ISSUE through WAIT); go to WAIT.
- WAIT:
  - Counts CORE_LAT cycles and samples core_spike_i on the last one.
  - Spike: increment spike_cnt_o, go to EMIT.
  - No spike: advance.
- EMIT:
  - ev_valid_o=1 and ev_nid_o=ID, held stable until ev_ready_i.
  - On the handshake: advance.
  - Backpressure stalls the whole sweep.
- Advance: if ID==N_NEURONS-1, go to DONE; else ID+1 and go to FETCH.
- DONE: done_o=1 for one cycle, then IDLE.
  - busy_o falls on the cycle after done_o.
- Timing with immediate ack and no spikes: each neuron takes 2+CORE_LAT cycles; the first syn_req_o is asserted the cycle after tick_i.
- Ticks outside IDLE (including in DONE) are dropped and set overrun_o on the next edge.
  - If a tick and ovr_clr_i arrive in the same cycle, the set wins.
  - overrun_o is otherwise cleared only by ovr_clr_i or reset.
- spike_cnt_o holds its value after DONE until the next accepted tick; max value is N_NEURONS, so no overflow.
- syn_cur_i is passed through unmodified; no saturation or width change.
- Asynchronous reset mid-sweep:
  - Abandons the sweep immediately and returns to IDLE.
  - Any in-flight event is dropped.
  - No done_o is produced.

Optional Feature:
- Macro: NEURON_TM_REFRACTORY_EN.
- With the macro:
  - Adds parameter REF_STEPS (default 2) and a per-neuron refractory counter array (N_NEURONS × $clog2(REF_STEPS+1) bits, reset 0).
  - A neuron whose spike is sampled loads REF_STEPS.
  - In later sweeps, a neuron with a nonzero counter still completes FETCH (the current is consumed and discarded), then skips ISSUE/WAIT/EMIT: no core_en_o, no event. Its counter decrements by 1 and the sweep advances.
- Without the macro: every neuron is issued every timestep, and no counter storage exists.

Test Plan:
- Test defaults: N_NEURONS=4, CORE_LAT=1, syn_ack_i tied 1, ev_ready_i tied 1.
- No spikes: tick at cycle 0 → syn_req_o at cycle 1; core_en_o at cycles 2,5,8,11 with core_nid_o 0..3; done_o at cycle 13; spike_cnt_o=0; busy_o low at cycle 14.
- Spikes on IDs 1 and 3: exactly two ev handshakes, ev_nid_o=1 then 3; spike_cnt_o=2; done_o after the event for ID 3.
- Backpressure: ev_ready_i low for 5 cycles during the ID 1 event → ev_valid_o/ev_nid_o stay stable; no syn_req_o for ID 2 until the handshake.
- Ack delay of 3 cycles on ID 0 with syn_cur_i=-300 → syn_nid_o held at 0; core_isyn_o=-300 during core_en_o.
- Overrun: tick again mid-sweep → overrun_o=1, sweep unaffected; ovr_clr_i pulse → 0; tick together with ovr_clr_i outside IDLE → overrun_o stays 1.
- Reset mid-EMIT → all outputs 0 next cycle; a new tick runs a clean sweep starting at ID 0. With NEURON_TM_REFRACTORY_EN and REF_STEPS=2: ID 2 spikes in sweep 1 → no core_en_o for ID 2 in sweeps 2 and 3 (syn_req_o still seen for ID 2), issued again in sweep 4.

Source files
------------

// File: rtl/neuron_tm_scheduler.sv
// neuron_tm_scheduler: time-multiplexes one shared LIF/STP neuron core across
// N_NEURONS virtual neurons. Each tick sweeps IDs 0..N_NEURONS-1:
// fetch current -> issue core -> wait CORE_LAT -> emit spike event.
// Optional build macro NEURON_TM_REFRACTORY_EN adds per-neuron refractory
// counters (REF_STEPS sweeps skipped after a spike).
module neuron_tm_scheduler #(
    parameter int N_NEURONS = 16,
    parameter int NID_W     = $clog2(N_NEURONS),
    parameter int WEIGHT_W  = 16,
    parameter int CORE_LAT  = 1
`ifdef NEURON_TM_REFRACTORY_EN
    ,
    parameter int REF_STEPS = 2
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick_i,
    output logic                       syn_req_o,
    output logic [NID_W-1:0]           syn_nid_o,
    input  logic                       syn_ack_i,
    input  logic signed [WEIGHT_W-1:0] syn_cur_i,
    output logic                       core_en_o,
    output logic [NID_W-1:0]           core_nid_o,
    output logic signed [WEIGHT_W-1:0] core_isyn_o,
    input  logic                       core_spike_i,
    output logic                       ev_valid_o,
    output logic [NID_W-1:0]           ev_nid_o,
    input  logic                       ev_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [NID_W:0]             spike_cnt_o,
    output logic                       overrun_o,
    input  logic                       ovr_clr_i
);

    localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [NID_W-1:0] LAST_ID = NID_W'(N_NEURONS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, EMIT, DONE} state_t;

    state_t                     state;
    logic [NID_W-1:0]           nid;
    logic signed [WEIGHT_W-1:0] cur_q;
    logic [LAT_W-1:0]           lat_cnt;

    logic syn_hs;
    logic ev_hs;
    logic lat_last;
    logic spike_hit;
    logic skip;
    logic adv;

`ifdef NEURON_TM_REFRACTORY_EN
    localparam int REF_W = $clog2(REF_STEPS + 1);
    logic [N_NEURONS-1:0][REF_W-1:0] ref_cnt;
`endif

    // The ID, latched current and event ID are single registers shared by all
    // three interfaces; each is only meaningful while its valid/strobe is up.
    assign syn_nid_o   = nid;
    assign core_nid_o  = nid;
    assign ev_nid_o    = nid;
    assign core_isyn_o = cur_q;

    assign syn_hs    = syn_req_o & syn_ack_i;
    assign ev_hs     = ev_valid_o & ev_ready_i;
    assign lat_last  = (lat_cnt == '0);
    assign spike_hit = (state == WAIT) && lat_last && core_spike_i;

    // Refractory neurons still complete the fetch handshake but skip the core
    always_comb begin
        skip = 1'b0;
`ifdef NEURON_TM_REFRACTORY_EN
        skip = (ref_cnt[nid] != '0);
`endif
        adv = ((state == WAIT) && lat_last && !core_spike_i) ||
              ((state == EMIT) && ev_hs) ||
              ((state == FETCH) && syn_hs && skip);
    end

    // Sweep FSM with registered handshake/strobe outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            nid         <= '0;
            cur_q       <= '0;
            lat_cnt     <= '0;
            syn_req_o   <= 1'b0;
            core_en_o   <= 1'b0;
            ev_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            spike_cnt_o <= '0;
            overrun_o   <= 1'b0;
        end else begin
            core_en_o <= 1'b0;
            done_o    <= 1'b0;

            // a dropped tick beats a simultaneous clear
            if (tick_i && state != IDLE)
                overrun_o <= 1'b1;
            else if (ovr_clr_i)
                overrun_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick_i) begin
                        nid         <= '0;
                        spike_cnt_o <= '0;
                        busy_o      <= 1'b1;
                        syn_req_o   <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (syn_hs) begin
                        syn_req_o <= 1'b0;
                        if (!skip) begin
                            cur_q     <= syn_cur_i;
                            core_en_o <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_W'(CORE_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (!lat_last) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else if (core_spike_i) begin
                        spike_cnt_o <= spike_cnt_o + 1'b1;
                        ev_valid_o  <= 1'b1;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (ev_hs)
                        ev_valid_o <= 1'b0;
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // common advance: next neuron or end of sweep (overrides case above)
            if (adv) begin
                if (nid == LAST_ID) begin
                    done_o <= 1'b1;
                    state  <= DONE;
                end else begin
                    nid       <= nid + 1'b1;
                    syn_req_o <= 1'b1;
                    state     <= FETCH;
                end
            end
        end
    end

`ifdef NEURON_TM_REFRACTORY_EN
    // Load on a sampled spike, count down once per skipped visit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_cnt <= '0;
        else if (spike_hit)
            ref_cnt[nid] <= REF_W'(REF_STEPS);
        else if (state == FETCH && syn_hs && skip)
            ref_cnt[nid] <= ref_cnt[nid] - 1'b1;
    end
`endif

endmodule

// File: tb/tb_neuron_tm_scheduler.sv
// Directed bench for neuron_tm_scheduler (N_NEURONS=4, CORE_LAT=1).
// A small core model returns mask[nid] one cycle after core_en_o.
module tb_neuron_tm_scheduler;
    localparam int N  = 4;
    localparam int NW = 2;
    localparam int WW = 16;

    logic clk = 1'b0, rst_n = 1'b0, tick_i = 1'b0, syn_ack_i = 1'b1;
    logic core_spike_i = 1'b0, ev_ready_i = 1'b1, ovr_clr_i = 1'b0;
    logic signed [WW-1:0] syn_cur_i = '0;
    logic syn_req_o, core_en_o, ev_valid_o, busy_o, done_o, overrun_o;
    logic [NW-1:0] syn_nid_o, core_nid_o, ev_nid_o;
    logic signed [WW-1:0] core_isyn_o;
    logic [NW:0] spike_cnt_o;

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [N-1:0] mask = '0;
    logic pend = 1'b0;
    int en_cnt [N] = '{default: 0};
    int req_cnt [N] = '{default: 0};
    int ev_total = 0;
    int ev_nid_log [64];
    int ev_cyc_log [64];

    neuron_tm_scheduler #(.N_NEURONS(N), .WEIGHT_W(WW), .CORE_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_i),
        .syn_req_o(syn_req_o), .syn_nid_o(syn_nid_o), .syn_ack_i(syn_ack_i), .syn_cur_i(syn_cur_i),
        .core_en_o(core_en_o), .core_nid_o(core_nid_o), .core_isyn_o(core_isyn_o),
        .core_spike_i(core_spike_i),
        .ev_valid_o(ev_valid_o), .ev_nid_o(ev_nid_o), .ev_ready_i(ev_ready_i),
        .busy_o(busy_o), .done_o(done_o), .spike_cnt_o(spike_cnt_o),
        .overrun_o(overrun_o), .ovr_clr_i(ovr_clr_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // core model plus handshake monitors, evaluated mid-cycle
    always @(negedge clk) begin
        core_spike_i = pend;
        pend = core_en_o && mask[core_nid_o];
        if (core_en_o) en_cnt[core_nid_o] += 1;
        if (syn_req_o && syn_ack_i) req_cnt[syn_nid_o] += 1;
        if (ev_valid_o && ev_ready_i && ev_total < 64) begin
            ev_nid_log[ev_total] = int'(ev_nid_o);
            ev_cyc_log[ev_total] = cyc;
            ev_total += 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick_i = 1'b0; ovr_clr_i = 1'b0;
        syn_ack_i = 1'b1; ev_ready_i = 1'b1; syn_cur_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start_sweep();
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
    endtask

    // leaves the bench in the DONE cycle
    task automatic wait_done(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (done_o) break;
            step();
        end
        chk(tag, done_o, 1);
    endtask

    task automatic wait_ev(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (ev_valid_o) break;
            step();
        end
        chk(tag, ev_valid_o, 1);
    endtask

    function automatic int en_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += en_cnt[i];
        return s;
    endfunction

    initial begin
        int e0, s0, dc;
        int en2, rq2;

        // reset state
        do_reset();
        chk("rst_syn_req", syn_req_o, 0);
        chk("rst_core_en", core_en_o, 0);
        chk("rst_ev_valid", ev_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_spike_cnt", spike_cnt_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_isyn", {16'h0, core_isyn_o}, 0);

        // no spikes: exact cycle schedule
        mask = 4'b0000;
        start_sweep();
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) begin
                chk("t1_syn_req", syn_req_o, 1);
                chk("t1_syn_nid", syn_nid_o, 0);
            end
            chk("t1_core_en", core_en_o, (c % 3 == 2) && (c <= 11));
            if ((c % 3 == 2) && (c <= 11)) chk("t1_core_nid", core_nid_o, (c - 2) / 3);
            chk("t1_done", done_o, c == 13);
            chk("t1_busy", busy_o, c <= 13);
            if (c < 14) step();
        end
        chk("t1_spike_cnt", spike_cnt_o, 0);

        // spikes on IDs 1 and 3
        do_reset();
        mask = 4'b1010;
        e0 = ev_total;
        start_sweep();
        wait_done("t2_done", 100);
        dc = cyc;
        step();
        chk("t2_ev_count", ev_total - e0, 2);
        chk("t2_ev0_nid", ev_nid_log[e0], 1);
        chk("t2_ev1_nid", ev_nid_log[e0 + 1], 3);
        chk("t2_spike_cnt", spike_cnt_o, 2);
        chk("t2_done_after_ev", dc > ev_cyc_log[e0 + 1], 1);
        chk("t2_busy_low", busy_o, 0);

        // backpressure for 5 cycles on the ID 1 event
        do_reset();
        mask = 4'b0010;
        e0 = ev_total;
        start_sweep();
        wait_ev("t3_ev_seen", 50);
        ev_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ev_valid", ev_valid_o, 1);
            chk("t3_ev_nid", ev_nid_o, 1);
            chk("t3_no_req", syn_req_o, 0);
            step();
        end
        ev_ready_i = 1'b1;
        chk("t3_ev_valid_end", ev_valid_o, 1);
        step();
        chk("t3_req_id2", syn_req_o, 1);
        chk("t3_nid_id2", syn_nid_o, 2);
        wait_done("t3_done", 100);
        step();
        chk("t3_ev_count", ev_total - e0, 1);
        chk("t3_spike_cnt", spike_cnt_o, 1);

        // 3-cycle ack delay on ID 0 with negative current
        do_reset();
        mask = 4'b0000;
        syn_ack_i = 1'b0;
        syn_cur_i = -16'sd300;
        start_sweep();
        for (int i = 0; i < 3; i++) begin
            chk("t4_req_held", syn_req_o, 1);
            chk("t4_nid_held", syn_nid_o, 0);
            chk("t4_no_en", core_en_o, 0);
            step();
        end
        syn_ack_i = 1'b1;
        step();
        chk("t4_core_en", core_en_o, 1);
        chk("t4_core_nid", core_nid_o, 0);
        chk("t4_isyn_issue", {16'h0, core_isyn_o}, 32'h0000FED4);
        step();
        chk("t4_isyn_wait", {16'h0, core_isyn_o}, 32'h0000FED4);
        wait_done("t4_done", 100);
        step();

        // overrun set / clear / set-wins
        do_reset();
        mask = 4'b0000;
        s0 = en_sum();
        start_sweep();
        step(); step(); step();
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        chk("t5_ovr_set", overrun_o, 1);
        chk("t5_busy", busy_o, 1);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        chk("t5_ovr_clr", overrun_o, 0);
        tick_i = 1'b1;
        ovr_clr_i = 1'b1;
        step();
        tick_i = 1'b0;
        ovr_clr_i = 1'b0;
        chk("t5_ovr_set_wins", overrun_o, 1);
        wait_done("t5_done", 100);
        step();
        chk("t5_en_count", en_sum() - s0, 4);
        chk("t5_ovr_sticky", overrun_o, 1);

        // async reset during EMIT, then a clean sweep
        do_reset();
        mask = 4'b0001;
        ev_ready_i = 1'b0;
        start_sweep();
        wait_ev("t6_ev_seen", 20);
        rst_n = 1'b0;
        #1;
        chk("t6_ev_valid", ev_valid_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_syn_req", syn_req_o, 0);
        chk("t6_core_en", core_en_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_spike_cnt", spike_cnt_o, 0);
        chk("t6_ev_nid", ev_nid_o, 0);
        rst_n = 1'b1;
        ev_ready_i = 1'b1;
        mask = 4'b0000;
        step();
        s0 = en_sum();
        e0 = ev_total;
        start_sweep();
        chk("t6_restart_req", syn_req_o, 1);
        chk("t6_restart_nid", syn_nid_o, 0);
        wait_done("t6_done", 100);
        step();
        chk("t6_en_count", en_sum() - s0, 4);
        chk("t6_ev_count", ev_total - e0, 0);

`ifdef NEURON_TM_REFRACTORY_EN
        // ID 2 spikes in sweep 1, skipped in sweeps 2-3, issued in sweep 4
        do_reset();
        mask = 4'b0100;
        for (int s = 0; s < 4; s++) begin
            en2 = en_cnt[2];
            rq2 = req_cnt[2];
            start_sweep();
            wait_done("ref_done", 100);
            step();
            chk("ref_en_id2", en_cnt[2] - en2, (s == 0 || s == 3) ? 1 : 0);
            chk("ref_req_id2", req_cnt[2] - rq2, 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
